// File: rtl/slave_serial_port.sv
// slave_serial_port: serial bus slave that deserialises address/burst/data and bridges to a simple synchronous memory port
module slave_serial_port #(
   parameter int ADDR_LEN        = 12,
   parameter int DATA_LEN        = 8,
   parameter int BURST_LEN       = 12,
   parameter int SPLIT_THRESHOLD = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                read_en,
   input  logic                write_en,
   input  logic                master_valid,
   input  logic                master_ready,
   input  logic                rx_address,
   input  logic                rx_data,
   input  logic                rx_burst,
   input  logic [5:0]          slave_delay,
   input  logic [DATA_LEN-1:0] mem_rdata,
   output logic                slave_ready,
   output logic                slave_valid,
   output logic                tx_data,
   output logic                split_en,
   output logic [ADDR_LEN-1:0] mem_addr,
   output logic [DATA_LEN-1:0] mem_wdata,
   output logic                mem_we,
   output logic                mem_re
);
   localparam int AB = ADDR_LEN > BURST_LEN ? ADDR_LEN : BURST_LEN;
   localparam int ML = AB > DATA_LEN ? AB : DATA_LEN;
   localparam int CW = $clog2(ML + 1);
   localparam logic [CW-1:0] A_END = CW'(AB - 1);
   localparam logic [CW-1:0] D_END = CW'(DATA_LEN - 1);
   localparam logic [CW-1:0] A_LEN = CW'(ADDR_LEN);
   localparam logic [CW-1:0] B_LEN = CW'(BURST_LEN);
   localparam logic [5:0]    SPLIT = 6'(SPLIT_THRESHOLD);

   typedef enum logic [2:0] {IDLE, ADDR, WDATA, WCOMMIT, WAIT, RFETCH, RSEND} state_t;
   state_t state, nxt;

   logic                 rd;
   logic [CW-1:0]        cnt;
   logic [BURST_LEN-1:0] burst, beat;
   logic [5:0]           wcnt;
   logic [DATA_LEN-1:0]  rbuf;
   logic                 start, shift_a, adv, last_beat;

   assign start     = state == IDLE && master_valid && (read_en ^ write_en);
   assign shift_a   = start || (state == ADDR && master_valid);
   assign adv       = shift_a || (state == WDATA && master_valid) || (state == RSEND && master_ready);
   // a burst value of zero still moves one beat
   assign last_beat = beat == (burst == '0 ? '0 : burst - 1'b1);
   assign tx_data   = rbuf[0];

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = start ? ADDR : IDLE;
         ADDR:    if (master_valid && cnt == A_END) nxt = !rd ? WDATA : slave_delay == '0 ? RFETCH : WAIT;
         WDATA:   if (master_valid && cnt == D_END) nxt = WCOMMIT;
         WCOMMIT: nxt = last_beat ? IDLE : WDATA;
         WAIT:    nxt = wcnt == '0 ? RFETCH : WAIT;
         RFETCH:  nxt = RSEND;
         RSEND:   if (master_ready && cnt == D_END) nxt = last_beat ? IDLE : RFETCH;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         rd          <= 1'b0;
         cnt         <= '0;
         burst       <= '0;
         beat        <= '0;
         wcnt        <= '0;
         rbuf        <= '0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         slave_ready <= 1'b0;
         slave_valid <= 1'b0;
         split_en    <= 1'b0;
         mem_we      <= 1'b0;
         mem_re      <= 1'b0;
      end else begin
         state       <= nxt;
         slave_ready <= nxt == IDLE || nxt == ADDR || nxt == WDATA;
         slave_valid <= nxt == RSEND;
         split_en    <= nxt == WAIT && slave_delay >= SPLIT;
         mem_we      <= nxt == WCOMMIT;
         mem_re      <= nxt == RFETCH;
         if (start) begin
            rd   <= read_en;
            beat <= '0;
         end
         if (adv) cnt <= (nxt != state && state != IDLE) ? '0 : cnt + 1'b1;
         // each field fills LSB-first and stops once its own width is reached
         if (shift_a && cnt < A_LEN) mem_addr <= {rx_address, mem_addr[ADDR_LEN-1:1]};
         if (shift_a && cnt < B_LEN) burst <= {rx_burst, burst[BURST_LEN-1:1]};
         if (state == ADDR && nxt == WAIT) wcnt <= slave_delay - 1'b1;
         if (state == WAIT) wcnt <= wcnt - 1'b1;
         if (state == WDATA && master_valid) mem_wdata <= {rx_data, mem_wdata[DATA_LEN-1:1]};
         if (state == RFETCH) rbuf <= mem_rdata;
         if (state == RSEND && master_ready) rbuf <= rbuf >> 1;
         if (state == WCOMMIT || (state == RSEND && nxt != RSEND)) begin
            mem_addr <= mem_addr + 1'b1;
            beat     <= beat + 1'b1;
         end
      end
   end
endmodule
